multiport_register_file: RTL and testbench
==========================================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per entry; legal values are multiples of 8, from 8 to 128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, address bits; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port we, input, 1, write enable.
REQ-006 SHALL have port wAddr, input, ADDR_WIDTH, write address.
REQ-007 SHALL have port wData, input, DATA_WIDTH, write data.
REQ-008 SHALL have port wBe, input, DATA_WIDTH/8, byte enables; bit i selects wData[8i+7:8i].
REQ-009 SHALL have port rAddrA, input, ADDR_WIDTH, read port A address.
REQ-010 SHALL have port rDataA, output, DATA_WIDTH, read port A data.
REQ-011 SHALL have port rAddrB, input, ADDR_WIDTH, read port B address.
REQ-012 SHALL have port rDataB, output, DATA_WIDTH, read port B data.
REQ-013 SHALL have port clr, input, 1, clear request; a one-cycle pulse is sufficient.
REQ-014 SHALL have port busy, output, 1, high while a clear sweep is in progress.
REQ-015 SHALL have port wDrop, output, 1, registered one-cycle pulse flagging a dropped write.

Function
REQ-016 SHALL hold DEPTH entries of DATA_WIDTH bits.
REQ-017 SHALL read combinationally on both ports (zero latency); rDataA and rDataB are independent and may address the same entry.
REQ-018 SHALL, on a write accepted at a clock edge, update only the wBe-selected bytes of entry wAddr; unselected bytes are kept.
REQ-019 SHALL treat we=1 with wBe=0 as an accepted no-op; it does not raise wDrop.
REQ-020 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-021 SHALL, in IDLE with clr=1, move to CLEAR on the next edge with the sweep counter at 0.
REQ-022 SHALL, in each CLEAR cycle, zero entry[counter] at the edge and increment the counter.
REQ-023 SHALL return to IDLE at the edge that clears entry DEPTH-1, so busy is high for exactly DEPTH cycles.
REQ-024 SHALL drive busy = (state == CLEAR).
REQ-025 SHALL ignore clr while in CLEAR; the sweep is not restarted.
REQ-026 SHALL drop a write when we=1 and either busy=1 or (IDLE and clr=1); clr wins over we in the same cycle.
REQ-027 SHALL, for each dropped write, assert wDrop for exactly one cycle after that edge; wDrop is otherwise 0.
REQ-028 SHALL, during CLEAR, let reads return the current stored contents; entries not yet swept still hold their old values.
REQ-029 SHALL let the sweep counter wrap modulo DEPTH, never indexing past DEPTH-1.

Reset
REQ-030 SHALL, while reset_n=0 and independent of clk, force all entries to 0, state to IDLE, counter to 0, busy to 0 and wDrop to 0.
REQ-031 SHALL, on reset asserted mid-sweep, abort the sweep; all entries are 0 after reset.
REQ-032 SHALL accept no writes while reset_n=0; the first write is taken at the first rising edge after release.

Configuration
REQ-033 SHALL use macro REGFILE_BYPASS_EN.
- Defined: when a write is being accepted this cycle (REQ-026 not dropping it) and rAddrX == wAddr, rDataX SHALL show the stored entry with its wBe-selected bytes replaced by wData, combinationally (write-first forwarding, both ports). Dropped writes are never forwarded.
- Undefined: rDataX SHALL show the stored value only; new data is visible the cycle after the write edge.

Verification
REQ-034 Reset then fill: write 0x11111111*k to address k (k=0..7) with wBe=0xF; read port A sweeps 0..7 and port B sweeps 7..0 -> each port returns 0x11111111*addr.
REQ-035 Byte enable: entry 3 = 0x33333333, write 0xAABBCCDD with wBe=0b0101 -> entry 3 reads 0x33BB33DD.
REQ-036 Clear: pulse clr with all entries nonzero -> busy high for 8 cycles; entry k reads 0 from the cycle after sweep edge k; busy falls after entry 7 is cleared.
REQ-037 Drops: we=1 with clr=1 in IDLE, and we=1 during busy, to address 5 with 0xFFFFFFFF -> entry 5 keeps its value; wDrop pulses one cycle for each drop.
REQ-038 Bypass: write 0x12345678 to address 2 with rAddrA=2 -> rDataA=0x12345678 in the same cycle with REGFILE_BYPASS_EN defined, old value without it; after the edge both builds read 0x12345678.
REQ-039 Reset mid-sweep: assert reset_n=0 at sweep cycle 3 -> busy=0 and every entry reads 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multiport_register_file.sv
// Multiport register file: one byte-masked write port, two combinational
// read ports, and a background clear sweep that zeroes one entry per cycle.
// Writes that collide with a clear request or an active sweep are dropped
// and flagged on wDrop.
//
// Build option: define REGFILE_BYPASS_EN to forward an accepted write to any
// read port addressing the same entry in the same cycle (write-first).
// Without it, reads show stored contents only.
module multiport_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   wAddr,
  input  logic [DATA_WIDTH-1:0]   wData,
  input  logic [DATA_WIDTH/8-1:0] wBe,
  input  logic [ADDR_WIDTH-1:0]   rAddrA,
  output logic [DATA_WIDTH-1:0]   rDataA,
  input  logic [ADDR_WIDTH-1:0]   rAddrB,
  output logic [DATA_WIDTH-1:0]   rDataB,
  input  logic                    clr,
  output logic                    busy,
  output logic                    wDrop
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweepCnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  writeAccept;
  logic                  writeDrop;

  // Replace the byte lanes selected by be with the matching lanes of data.
  function automatic logic [DATA_WIDTH-1:0] mergeBytes(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] data,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  // A write only lands from IDLE with no clear request; clr wins over we.
  // Gating with reset_n keeps a held write from being forwarded during reset.
  assign writeAccept = reset_n && we && (state == IDLE) && !clr;
  assign writeDrop   = we && ((state == CLEAR) || clr);

  assign busy = (state == CLEAR);

  // Sweep FSM and the registered drop flag.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sweepCnt <= '0;
      wDrop    <= 1'b0;
    end else begin
      wDrop <= writeDrop;
      case (state)
        IDLE: begin
          if (clr) begin
            state    <= CLEAR;
            sweepCnt <= '0;
          end
        end
        CLEAR: begin
          // Counter is ADDR_WIDTH bits wide, so it wraps modulo DEPTH.
          sweepCnt <= sweepCnt + ADDR_WIDTH'(1);
          if (sweepCnt == LAST_ENTRY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: sweep zeroing has priority; writes are never accepted in CLEAR.
  // NOTE: the array is reset because zeroed contents after reset are
  // architecturally visible; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[sweepCnt] <= '0;
    end else if (writeAccept) begin
      mem[wAddr] <= mergeBytes(mem[wAddr], wData, wBe);
    end
  end

  // Combinational read ports, optionally with write-first forwarding.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    rDataA = mem[rAddrA];
    rDataB = mem[rAddrB];
`ifdef REGFILE_BYPASS_EN
    if (writeAccept && (rAddrA == wAddr)) rDataA = mergeBytes(mem[rAddrA], wData, wBe);
    if (writeAccept && (rAddrB == wAddr)) rDataB = mergeBytes(mem[rAddrB], wData, wBe);
`endif
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file (default parameters).
// A behavioural model tracks contents, clear progress and drop pulses.
module tb_multiport_register_file;

  logic        clk;
  logic        reset_n;
  logic        we;
  logic [2:0]  wAddr;
  logic [31:0] wData;
  logic [3:0]  wBe;
  logic [2:0]  rAddrA;
  logic [31:0] rDataA;
  logic [2:0]  rAddrB;
  logic [31:0] rDataB;
  logic        clr;
  logic        busy;
  logic        wDrop;

  multiport_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData),
    .wBe(wBe), .rAddrA(rAddrA), .rDataA(rDataA), .rAddrB(rAddrB),
    .rDataB(rDataB), .clr(clr), .busy(busy), .wDrop(wDrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;

  // Model: plain contents plus how many sweep cycles are still to come.
  logic [31:0] modelMem [8];
  int          clearRemaining;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] expRead;
  } FillVec;

  FillVec vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelMerge(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic logic modelAccepts();
    return reset_n && we && (clearRemaining == 0) && !clr;
  endfunction

  function automatic logic [31:0] expRead(input logic [2:0] addr);
    logic [31:0] v;
    v = modelMem[addr];
`ifdef REGFILE_BYPASS_EN
    if (modelAccepts() && addr == wAddr) v = modelMerge(v, wData, wBe);
`endif
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) modelMem[i] = 32'h0;
    clearRemaining = 0;
  endtask

  // One clock cycle: drive, check reads pre-edge, advance model, check flags.
  task automatic doCycle(input logic iWe, input logic [2:0] iAddr, input logic [31:0] iData,
                         input logic [3:0] iBe, input logic iClr);
    logic accepted;
    logic expDrop;
    we = iWe; wAddr = iAddr; wData = iData; wBe = iBe; clr = iClr;
    #1;
    check("rDataA", rDataA, expRead(rAddrA));
    check("rDataB", rDataB, expRead(rAddrB));
    accepted = modelAccepts();
    expDrop  = iWe && ((clearRemaining > 0) || iClr);
    @(posedge clk);
    if (clearRemaining > 0) begin
      modelMem[8 - clearRemaining] = 32'h0;
      clearRemaining--;
    end else if (iClr) begin
      clearRemaining = 8;
    end
    if (accepted) modelMem[iAddr] = modelMerge(modelMem[iAddr], iData, iBe);
    #1;
    check("busy", {31'h0, busy}, {31'h0, clearRemaining > 0});
    check("wDrop", {31'h0, wDrop}, {31'h0, expDrop});
    we = 1'b0; clr = 1'b0;
  endtask

  initial begin
    int busyCnt;
    logic [31:0] bypassExp;

    for (int k = 0; k < 8; k++) begin
      vecs[k].addr    = 3'(k);
      vecs[k].data    = 32'h11111111 * k;
      vecs[k].be      = 4'hF;
      vecs[k].expRead = 32'h11111111 * k;
    end
    vecs[8].addr = 3'd3; vecs[8].data = 32'hAABBCCDD; vecs[8].be = 4'b0101;
    vecs[8].expRead = 32'h33BB33DD;

    reset_n = 1'b0; we = 1'b0; wAddr = '0; wData = '0; wBe = '0;
    rAddrA = '0; rAddrB = 3'd7; clr = 1'b0;
    modelReset();

    // Reset state
    #12;
    check("resetBusy", {31'h0, busy}, 32'h0);
    check("resetDrop", {31'h0, wDrop}, 32'h0);
    check("resetReadA", rDataA, 32'h0);
    check("resetReadB", rDataB, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Fill with full byte enables, reading each entry back
    for (int i = 0; i < 8; i++) begin
      doCycle(1'b1, vecs[i].addr, vecs[i].data, vecs[i].be, 1'b0);
      rAddrA = vecs[i].addr;
      #1;
      check("fillRead", rDataA, vecs[i].expRead);
    end

    // Port A sweeps up while port B sweeps down
    for (int k = 0; k < 8; k++) begin
      rAddrA = 3'(k); rAddrB = 3'(7 - k);
      #1;
      check("sweepReadA", rDataA, 32'h11111111 * k);
      check("sweepReadB", rDataB, 32'h11111111 * (7 - k));
    end

    // Byte-enabled partial write
    doCycle(1'b1, vecs[8].addr, vecs[8].data, vecs[8].be, 1'b0);
    rAddrA = vecs[8].addr;
    #1;
    check("byteEnable", rDataA, vecs[8].expRead);

    // we with no byte lanes is an accepted no-op
    doCycle(1'b1, 3'd3, 32'hFFFFFFFF, 4'h0, 1'b0);
    check("beZeroKeep", rDataA, 32'h33BB33DD);

    // Same-cycle forwarding vs. stored value
    rAddrA = 3'd2;
    we = 1'b1; wAddr = 3'd2; wData = 32'h12345678; wBe = 4'hF; clr = 1'b0;
    #1;
`ifdef REGFILE_BYPASS_EN
    bypassExp = 32'h12345678;
`else
    bypassExp = 32'h22222222;
`endif
    check("bypassSameCycle", rDataA, bypassExp);
    doCycle(1'b1, 3'd2, 32'h12345678, 4'hF, 1'b0);
    check("bypassAfterEdge", rDataA, 32'h12345678);

    // Make entry 0 nonzero, then clear with a colliding write (clr wins)
    doCycle(1'b1, 3'd0, 32'hDEAD0000, 4'hF, 1'b0);
    rAddrB = 3'd5;
    doCycle(1'b1, 3'd5, 32'hFFFFFFFF, 4'hF, 1'b1);
    check("dropOnClr", {31'h0, wDrop}, 32'h1);
    busyCnt = busy ? 1 : 0;
    for (int j = 0; j < 10; j++) begin
      rAddrA = 3'(j);
      doCycle((j < 4) || (j == 6), 3'd5, 32'hFFFFFFFF, 4'hF, j == 2);
      if (busy) busyCnt++;
      if (j < 8) check("sweptEntry", rDataA, 32'h0);
    end
    check("busyCycles", busyCnt, 32'd8);
    rAddrA = 3'd5;
    #1;
    check("entry5Kept", rDataA, 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      rAddrA = 3'($urandom_range(0, 7));
      rAddrB = 3'($urandom_range(0, 7));
      doCycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
    end

    // Let any sweep finish (bounded), then refill with nonzero data
    for (int n = 0; n < 10 && clearRemaining > 0; n++) doCycle(1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
    check("sweepDrained", clearRemaining, 32'd0);
    for (int k = 0; k < 8; k++) doCycle(1'b1, 3'(k), 32'hA0000000 | k, 4'hF, 1'b0);

    // Reset asserted at sweep cycle 3
    doCycle(1'b0, 3'd0, 32'h0, 4'h0, 1'b1);
    for (int j = 0; j < 3; j++) doCycle(1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
    reset_n = 1'b0;
    modelReset();
    #1;
    check("midResetBusy", {31'h0, busy}, 32'h0);
    check("midResetDrop", {31'h0, wDrop}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      rAddrA = 3'(k); rAddrB = 3'(k + 4);
      #1;
      check("midResetReadA", rDataA, 32'h0);
      check("midResetReadB", rDataB, 32'h0);
    end

    // Writes are ignored while reset is held across an edge
    we = 1'b1; wAddr = 3'd1; wData = 32'hFFFFFFFF; wBe = 4'hF;
    rAddrA = 3'd1;
    @(posedge clk); #1;
    check("noWriteInReset", rDataA, 32'h0);
    we = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // First write after release is taken
    doCycle(1'b1, 3'd1, 32'h5A5A5A5A, 4'hF, 1'b0);
    check("writeAfterReset", rDataA, 32'h5A5A5A5A);
    doCycle(1'b0, 3'd0, 32'h0, 4'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
